// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI read-side RAM bridge.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [2:0] RESP_OKAY   = 3'd0;
  localparam logic [2:0] RESP_SLVERR = 3'd2;

  // The beat struct is sized for the widest supported configuration so it can be
  // shared by every instance; unused upper bits are constant zero and get pruned.
  localparam int R_ID_MAX_W   = 32;
  localparam int R_DATA_MAX_W = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DRAIN
  } rd_state_t;

  typedef struct packed {
    logic [R_ID_MAX_W-1:0]   rid;
    logic [R_DATA_MAX_W-1:0] rdata;
    logic [2:0]              rresp;
    logic                    rlast;
  } r_beat_t;

endpackage

// File: rtl/axi_ram_reader_fifo.sv
// Two-entry output buffer for R beats. A push into a full buffer is accepted only
// when a pop happens in the same cycle; the reader's credit scheme guarantees that.
module axi_ram_reader_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  // Decide which side moves this cycle; full-with-pop still accepts a push.
  always_comb begin
    do_pop  = out_valid && out_ready;
    do_push = in_valid && ((count != 2'd2) || do_pop);
  end

  // Storage, pointers and occupancy; reset empties the buffer and zeroes the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/axi_ram_reader.sv
// AXI4 read-channel slave that turns one AR burst at a time into single-cycle
// RAM reads and streams the words back as R beats through a 2-entry buffer.
module axi_ram_reader
  import axi_ram_pkg::*;
#(
  parameter int  AXI_DATA_W = 128,
  parameter int  AXI_ADDR_W = 16,
  parameter int  AXI_ID_W   = 8,
  localparam int BYTE_W     = $clog2(AXI_DATA_W / 8),
  localparam int RAM_ADDR_W = AXI_ADDR_W - BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_ar_arvalid,
  output logic                  axi_ar_arready,
  input  logic [AXI_ID_W-1:0]   axi_ar_arid,
  input  logic [AXI_ADDR_W-1:0] axi_ar_araddr,
  input  logic [3:0]            axi_ar_arregion,
  input  logic [7:0]            axi_ar_arlen,
  input  logic [2:0]            axi_ar_arsize,
  input  logic [1:0]            axi_ar_arburst,
  input  logic [2:0]            axi_ar_arprot,
  input  logic [3:0]            axi_ar_arcache,
  input  logic [3:0]            axi_ar_arqos,
  output logic                  axi_r_rvalid,
  input  logic                  axi_r_rready,
  output logic [AXI_ID_W-1:0]   axi_r_rid,
  output logic [AXI_DATA_W-1:0] axi_r_rdata,
  output logic [2:0]            axi_r_rresp,
  output logic                  axi_r_rlast,
  output logic                  ram_rd_en,
  output logic [RAM_ADDR_W-1:0] ram_rd_addr,
  input  logic [AXI_DATA_W-1:0] ram_rd_data
);

  rd_state_t             state;
  rd_state_t             next_state;
  logic                  arready_q;

  logic [AXI_ID_W-1:0]   id_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [7:0]            issue_cnt;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic                  accept;
  logic                  issue;
  logic                  rd_en;
  logic                  err_beat;
  logic                  ar_err;
  logic                  issue_last;
  logic                  credit_ok;
  logic [2:0]            used;
  logic [AXI_ADDR_W-1:0] addr_step;

  r_beat_t               beat_in;
  r_beat_t               beat_out;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_out_valid;
  logic [1:0]            fifo_count;

  logic                  unused_inputs;

  assign axi_ar_arready = arready_q;
  assign ram_rd_en      = rd_en;
  assign ram_rd_addr    = addr_q[AXI_ADDR_W-1:BYTE_W];

  assign axi_r_rvalid   = fifo_out_valid;
  assign axi_r_rid      = beat_out.rid[AXI_ID_W-1:0];
  assign axi_r_rdata    = beat_out.rdata[AXI_DATA_W-1:0];
  assign axi_r_rresp    = beat_out.rresp;
  assign axi_r_rlast    = beat_out.rlast;
  assign fifo_pop       = fifo_out_valid && axi_r_rready;

  assign unused_inputs  = ^{axi_ar_arregion, axi_ar_arcache, axi_ar_arqos,
                            axi_ar_arprot, beat_out};

  // Burst bookkeeping: error classification, address step, and buffer credit.
  // Credit counts the slot freed by a pop this cycle so a full-rate stream keeps
  // one beat buffered and one read in flight without ever overflowing.
  always_comb begin
    ar_err     = (int'(axi_ar_arsize) > BYTE_W) || (axi_ar_arburst >= BURST_WRAP);
    issue_last = (issue_cnt == len_q);
    addr_step  = (burst_q == BURST_FIXED) ? '0 : (AXI_ADDR_W'(1) << size_q);
    used       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    credit_ok  = (used < 3'd2);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle strobes: accept in IDLE, issue beats in BURST,
  // wait for the final handshake in DRAIN.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue      = 1'b0;
    rd_en      = 1'b0;
    err_beat   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (axi_ar_arvalid && arready_q) begin
          accept     = 1'b1;
          next_state = ST_BURST;
        end
      end
      ST_BURST: begin
        if (credit_ok) begin
          issue    = 1'b1;
          rd_en    = !err_q;
          err_beat = err_q;
          if (issue_last) begin
            next_state = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && beat_out.rlast) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request capture, address/beat advance, and tracking of the read in flight.
  // arready is registered so it stays low during reset and returns one cycle
  // after the last beat is handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_q       <= 1'b0;
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      size_q          <= '0;
      burst_q         <= '0;
      err_q           <= 1'b0;
      issue_cnt       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      arready_q <= (next_state == ST_IDLE);
      if (accept) begin
        id_q      <= axi_ar_arid;
        addr_q    <= axi_ar_araddr;
        len_q     <= axi_ar_arlen;
        size_q    <= axi_ar_arsize;
        burst_q   <= axi_ar_arburst;
        err_q     <= ar_err;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 8'd1;
        addr_q    <= addr_q + addr_step;
      end
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && issue_last;
    end
  end

  // Assemble the beat entering the buffer: returning RAM data, or a zero SLVERR beat.
  always_comb begin
    beat_in     = '0;
    beat_in.rid = R_ID_MAX_W'(id_q);
    if (err_beat) begin
      beat_in.rresp = RESP_SLVERR;
      beat_in.rlast = issue_last;
    end else begin
      beat_in.rdata = R_DATA_MAX_W'(ram_rd_data);
      beat_in.rresp = RESP_OKAY;
      beat_in.rlast = inflight_last_q;
    end
    fifo_push = inflight_q || err_beat;
  end

  axi_ram_reader_fifo #(
    .WIDTH($bits(r_beat_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (fifo_push),
    .in_data  (beat_in),
    .out_valid(fifo_out_valid),
    .out_ready(axi_r_rready),
    .out_data (beat_out),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_axi_ram_reader.sv
// Scoreboard bench for axi_ram_reader: directed bursts push expected beats and
// RAM addresses into queues; a negedge monitor pops and compares.
module tb_axi_ram_reader;

  localparam int DW = 128;
  localparam int AW = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [IW-1:0] arid = '0;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic          rvalid;
  logic          rready = 1'b1;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [2:0]    rresp;
  logic          rlast;
  logic          ram_rd_en;
  logic [11:0]   ram_rd_addr;
  logic [DW-1:0] ram_rd_data = '0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [2:0]    resp;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  logic [11:0] addr_exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int lat_exp = 0;
  int rd_cnt = 0;
  int beats_seen = 0;
  bit lat_armed = 0;
  bit toggle_ready = 0;
  bit want_arready = 0;
  bit prev_stall = 0;

  axi_ram_reader #(
    .AXI_DATA_W(DW),
    .AXI_ADDR_W(AW),
    .AXI_ID_W  (IW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .axi_ar_arvalid (arvalid),
    .axi_ar_arready (arready),
    .axi_ar_arid    (arid),
    .axi_ar_araddr  (araddr),
    .axi_ar_arregion(4'h0),
    .axi_ar_arlen   (arlen),
    .axi_ar_arsize  (arsize),
    .axi_ar_arburst (arburst),
    .axi_ar_arprot  (3'h0),
    .axi_ar_arcache (4'h0),
    .axi_ar_arqos   (4'h0),
    .axi_r_rvalid   (rvalid),
    .axi_r_rready   (rready),
    .axi_r_rid      (rid),
    .axi_r_rdata    (rdata),
    .axi_r_rresp    (rresp),
    .axi_r_rlast    (rlast),
    .ram_rd_en      (ram_rd_en),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rd_data    (ram_rd_data)
  );

  always #5 clk = ~clk;

  // RAM contents: word 1 is all A5, other words carry their own index.
  function automatic logic [DW-1:0] ram_word(input logic [11:0] w);
    if (w == 12'd1) return {16{8'hA5}};
    return {8{4'hD, w}};
  endfunction

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd_en) ram_rd_data <= ram_word(ram_rd_addr);
  end

  // rready is held high or toggled every cycle, changing just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rready = toggle_ready ? ~rready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=present required=absent", name);
  endtask

  task automatic expectBeat(input logic [IW-1:0] id, input logic [DW-1:0] data,
                            input logic [2:0] resp, input logic last);
    beat_t b;
    b.id = id; b.data = data; b.resp = resp; b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic applyStimulus(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int lat);
    int n;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ar_accept", {127'd0, arready}, 1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    hs_cyc = cyc;
    lat_exp = lat;
    lat_armed = 1;
  endtask

  task automatic waitDone(input string name, input int reads);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && addr_exp_q.size() == 0 && arready) && n < 200);
    checkOutput({name, "_beats_left"}, exp_q.size(), 0);
    checkOutput({name, "_reads"}, rd_cnt, reads);
    rd_cnt = 0;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_arready"}, {127'd0, arready}, 0);
    checkOutput({name, "_rvalid"}, {127'd0, rvalid}, 0);
    checkOutput({name, "_rlast"}, {127'd0, rlast}, 0);
    checkOutput({name, "_rid"}, rid, 0);
    checkOutput({name, "_rdata"}, rdata, 0);
    checkOutput({name, "_rresp"}, rresp, 0);
    checkOutput({name, "_ram_rd_en"}, {127'd0, ram_rd_en}, 0);
    checkOutput({name, "_ram_rd_addr"}, ram_rd_addr, 0);
  endtask

  // Monitor: compares RAM reads and R beats against the queues, plus latency,
  // rvalid persistence and arready return after the last beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 0;
      want_arready = 0;
      lat_armed = 0;
    end else begin
      if (want_arready) begin
        checkOutput("arready_after_rlast", {127'd0, arready}, 1);
        want_arready = 0;
      end
      if (prev_stall) checkOutput("rvalid_held", {127'd0, rvalid}, 1);
      if (ram_rd_en) begin
        rd_cnt++;
        if (addr_exp_q.size() > 0) checkOutput("ram_rd_addr", ram_rd_addr, addr_exp_q.pop_front());
        else failNow("unexpected_ram_read");
      end
      if (rvalid && lat_armed) begin
        checkOutput("first_rvalid_cycle", cyc - hs_cyc + 1, lat_exp);
        lat_armed = 0;
      end
      if (rvalid && rready) begin
        beats_seen++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("rid", rid, e.id);
          checkOutput("rdata", rdata, e.data);
          checkOutput("rresp", rresp, e.resp);
          checkOutput("rlast", {127'd0, rlast}, {127'd0, e.last});
          if (e.last) want_arready = 1;
        end else begin
          failNow("unexpected_beat");
        end
      end
      prev_stall = rvalid && !rready;
    end
  end

  initial begin
    int base;
    int n;
    #3;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;
    checkOutput("arready_in_first_cycle", {127'd0, arready}, 0);
    @(posedge clk);
    #1;
    checkOutput("arready_after_release", {127'd0, arready}, 1);

    // INCR single beat from word 1.
    expectBeat(8'h11, {16{8'hA5}}, 3'd0, 1'b1);
    addr_exp_q.push_back(12'h001);
    applyStimulus(8'h11, 16'h0010, 8'd0, 3'd4, 2'd1, 3);
    waitDone("incr1", 1);

    // INCR 4 beats with rready toggling.
    toggle_ready = 1;
    for (int i = 0; i < 4; i++) begin
      expectBeat(8'h22, ram_word(12'(i)), 3'd0, i == 3);
      addr_exp_q.push_back(12'(i));
    end
    applyStimulus(8'h22, 16'h0000, 8'd3, 3'd4, 2'd1, 3);
    waitDone("incr4_stall", 4);
    toggle_ready = 0;

    // FIXED 3 beats at word 4.
    for (int i = 0; i < 3; i++) begin
      expectBeat(8'h33, {8{16'hD004}}, 3'd0, i == 2);
      addr_exp_q.push_back(12'h004);
    end
    applyStimulus(8'h33, 16'h0040, 8'd2, 3'd4, 2'd0, 3);
    waitDone("fixed3", 3);

    // WRAP is rejected: two zero SLVERR beats, no RAM reads.
    expectBeat(8'h44, '0, 3'd2, 1'b0);
    expectBeat(8'h44, '0, 3'd2, 1'b1);
    applyStimulus(8'h44, 16'h0080, 8'd1, 3'd4, 2'd2, 2);
    waitDone("wrap_err", 0);

    // Oversized beat is rejected the same way.
    expectBeat(8'h55, '0, 3'd2, 1'b0);
    expectBeat(8'h55, '0, 3'd2, 1'b1);
    applyStimulus(8'h55, 16'h0000, 8'd1, 3'd5, 2'd1, 2);
    waitDone("size_err", 0);

    // Address wraps from the top of the space back to zero.
    expectBeat(8'h66, {8{16'hDFFF}}, 3'd0, 1'b0);
    expectBeat(8'h66, {8{16'hD000}}, 3'd0, 1'b1);
    addr_exp_q.push_back(12'hFFF);
    addr_exp_q.push_back(12'h000);
    applyStimulus(8'h66, 16'hFFF0, 8'd1, 3'd4, 2'd1, 3);
    waitDone("addr_wrap", 2);

    // Narrow 4-byte INCR from 0x4: bytes 4,8,12 in word 0, then 16,20 in word 1.
    expectBeat(8'h77, {8{16'hD000}}, 3'd0, 1'b0);
    expectBeat(8'h77, {8{16'hD000}}, 3'd0, 1'b0);
    expectBeat(8'h77, {8{16'hD000}}, 3'd0, 1'b0);
    expectBeat(8'h77, {16{8'hA5}}, 3'd0, 1'b0);
    expectBeat(8'h77, {16{8'hA5}}, 3'd0, 1'b1);
    addr_exp_q.push_back(12'h000);
    addr_exp_q.push_back(12'h000);
    addr_exp_q.push_back(12'h000);
    addr_exp_q.push_back(12'h001);
    addr_exp_q.push_back(12'h001);
    applyStimulus(8'h77, 16'h0004, 8'd4, 3'd2, 2'd1, 3);
    waitDone("narrow", 5);

    // Reset lands during an 8-beat burst after two beats have gone out.
    for (int i = 0; i < 8; i++) begin
      expectBeat(8'h88, ram_word(12'(16 + i)), 3'd0, i == 7);
      addr_exp_q.push_back(12'(16 + i));
    end
    base = beats_seen;
    applyStimulus(8'h88, 16'h0100, 8'd7, 3'd4, 2'd1, 3);
    n = 0;
    while (beats_seen < base + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("beats_before_reset", beats_seen - base, 2);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    exp_q.delete();
    addr_exp_q.delete();
    rd_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("arready_post_reset", {127'd0, arready}, 0);
    @(posedge clk);
    #1;
    checkOutput("arready_post_reset_edge", {127'd0, arready}, 1);

    // Fresh burst after reset returns only its own beat.
    expectBeat(8'h99, {8{16'hD002}}, 3'd0, 1'b1);
    addr_exp_q.push_back(12'h002);
    applyStimulus(8'h99, 16'h0020, 8'd0, 3'd4, 2'd1, 3);
    waitDone("after_reset", 1);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
